// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, colour constants, controller state encoding
// and the alignment-pipeline record.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int VGA_ADDR_W   = 19;
    localparam int CNT_W        = 10;

    // RGB444 colours shared with the colour-bar pattern generator
    localparam logic [11:0] RGB_BLACK = 12'h000;
    localparam logic [11:0] RGB_RED   = 12'hF00;
    localparam logic [11:0] RGB_GREEN = 12'h0F0;
    localparam logic [11:0] RGB_BLUE  = 12'h00F;
    localparam logic [11:0] RGB_WHITE = 12'hFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } vga_state_e;

    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
        logic src;
    } pipe_t;

endpackage

// File: rtl/vga_display_controller_timing_counter.sv
// Raster h/v counters with wrap, sync and active-area decode (stage 0).
module vga_timing_counter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    output logic hsync_o,
    output logic vsync_o,
    output logic active_o,
    output logic frame_start_o,
    output logic wrap_o
);

    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (!run_i) begin
            h_d = '0;
            v_d = '0;
        end else if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end else begin
            h_d = h_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign hsync_o       = run_i && (h_q >= HS_START) && (h_q < HS_END);
    assign vsync_o       = run_i && (v_q >= VS_START) && (v_q < VS_END);
    assign active_o      = run_i && (h_q < H_ACT) && (v_q < V_ACT);
    assign frame_start_o = run_i && (h_q == '0) && (v_q == '0);
    assign wrap_o        = run_i && (h_q == H_LAST) && (v_q == V_LAST);

endmodule

// File: rtl/vga_display_controller.sv
// VGA pixel-path sequencer: run/drain FSM, per-frame source latch, frame-buffer
// address generator and a 2-stage pipeline aligning sync, DE and RGB.
//
// state    | meaning
// ST_IDLE  | counters parked at (0,0), outputs quiet
// ST_RUN   | raster running, enable requested
// ST_DRAIN | enable dropped, finishing the current frame
module vga_display_controller
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit SYNC_POL = 1'b0,
    parameter int ADDR_W   = VGA_ADDR_W
) (
    input  logic              CLK_25_I,
    input  logic              RST_I,
    input  logic              ENABLE_I,
    input  logic              SRC_SEL_I,
    output logic              PAT_EN_O,
    input  logic [11:0]       PAT_PIXEL_I,
    output logic              FB_RD_EN_O,
    output logic [ADDR_W-1:0] FB_ADDR_O,
    input  logic [11:0]       FB_PIXEL_I,
    output logic [11:0]       VGA_RGB_O,
    output logic              HSYNC_O,
    output logic              VSYNC_O,
    output logic              DE_O,
    output logic              FRAME_START_O,
    output logic              BUSY_O
);

    vga_state_e        state_q, state_d;
    logic              run, active, hsync, vsync, frame_start, wrap;
    logic              src_q, src_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    pipe_t             pipe1_q, pipe1_d, pipe2_q, pipe2_d;
    logic [11:0]       pat_pix_q, pat_pix_d, fb_pix_q, fb_pix_d;

    assign run = (state_q != ST_IDLE);

    vga_timing_counter #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk          (CLK_25_I),
        .rst          (RST_I),
        .run_i        (run),
        .hsync_o      (hsync),
        .vsync_o      (vsync),
        .active_o     (active),
        .frame_start_o(frame_start),
        .wrap_o       (wrap)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (ENABLE_I) state_d = ST_RUN;
            ST_RUN:   if (!ENABLE_I) state_d = wrap ? ST_IDLE : ST_DRAIN;
            ST_DRAIN: begin
                if (ENABLE_I)  state_d = ST_RUN;
                else if (wrap) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // src_d doubles as the stage-0 source so the first pixel uses the new selection
    always_comb begin
        src_d  = frame_start ? SRC_SEL_I : src_q;
        addr_d = addr_q;
        if (!run || wrap) addr_d = '0;
        else if (active)  addr_d = addr_q + 1'b1;
        pipe1_d   = '{hs: hsync, vs: vsync, act: active, src: src_d};
        pipe2_d   = pipe1_q;
        pat_pix_d = PAT_PIXEL_I;
        fb_pix_d  = FB_PIXEL_I;
    end

    always_ff @(posedge CLK_25_I) begin
        if (RST_I) begin
            state_q   <= ST_IDLE;
            src_q     <= 1'b0;
            addr_q    <= '0;
            pipe1_q   <= '0;
            pipe2_q   <= '0;
            pat_pix_q <= '0;
            fb_pix_q  <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            addr_q    <= addr_d;
            pipe1_q   <= pipe1_d;
            pipe2_q   <= pipe2_d;
            pat_pix_q <= pat_pix_d;
            fb_pix_q  <= fb_pix_d;
        end
    end

    assign PAT_EN_O      = active && !src_d;
    assign FB_RD_EN_O    = active && src_d;
    assign FB_ADDR_O     = addr_q;
    assign FRAME_START_O = frame_start;
    assign BUSY_O        = run;
    assign HSYNC_O       = pipe2_q.hs ? SYNC_POL : ~SYNC_POL;
    assign VSYNC_O       = pipe2_q.vs ? SYNC_POL : ~SYNC_POL;
    assign DE_O          = pipe2_q.act;
    assign VGA_RGB_O     = !pipe2_q.act ? RGB_BLACK : (pipe2_q.src ? fb_pix_q : pat_pix_q);

endmodule

// File: tb/tb_vga_display_controller.sv
// Self-checking bench for vga_display_controller on a scaled-down raster
// (28 x 13 clocks per frame) with a behavioural raster model and RAM/pattern sources.
module tb_vga_display_controller;
    import vga_pkg::*;

    localparam int HA = 16, HF = 3, HS = 5, HB = 4;
    localparam int VA = 6,  VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;   // 28
    localparam int VT = VA + VF + VS + VB;   // 13
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          RST_I, ENABLE_I, SRC_SEL_I;
    logic          PAT_EN_O, FB_RD_EN_O, HSYNC_O, VSYNC_O, DE_O, FRAME_START_O, BUSY_O;
    logic [11:0]   PAT_PIXEL_I, FB_PIXEL_I, VGA_RGB_O;
    logic [AW-1:0] FB_ADDR_O;

    always #20 clk = ~clk;

    vga_display_controller #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0), .ADDR_W(AW)
    ) dut (
        .CLK_25_I(clk), .RST_I(RST_I), .ENABLE_I(ENABLE_I), .SRC_SEL_I(SRC_SEL_I),
        .PAT_EN_O(PAT_EN_O), .PAT_PIXEL_I(PAT_PIXEL_I),
        .FB_RD_EN_O(FB_RD_EN_O), .FB_ADDR_O(FB_ADDR_O), .FB_PIXEL_I(FB_PIXEL_I),
        .VGA_RGB_O(VGA_RGB_O), .HSYNC_O(HSYNC_O), .VSYNC_O(VSYNC_O), .DE_O(DE_O),
        .FRAME_START_O(FRAME_START_O), .BUSY_O(BUSY_O)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- sources: pattern generator and 1-cycle RAM ----------------
    bit          pat_const = 1'b1;
    logic [11:0] pat_cur = 12'h000;
    bit          pat_en_prev = 1'b0, fb_en_prev = 1'b0;
    logic [AW-1:0] fb_addr_prev = '0;

    always @(posedge clk) begin
        #1;
        pat_cur     = pat_const ? RGB_RED : 12'($urandom);
        PAT_PIXEL_I = pat_en_prev ? pat_cur : ~pat_cur;
        FB_PIXEL_I  = fb_en_prev ? {4'h0, fb_addr_prev} : 12'hBAD;
    end

    // ---------------- behavioural raster model ----------------
    bit   m_run = 0, m_src = 0;
    int   m_h = 0, m_v = 0;
    bit   e1_hs = 0, e1_vs = 0, e1_de = 0, e1_src = 0;
    int   e1_addr = 0;
    bit   e2_hs = 0, e2_vs = 0, e2_de = 0;
    logic [11:0] e2_rgb = 12'h000;

    always @(negedge clk) begin
        bit fs, src0, de0, hs0, vs0;
        int addr0;
        fs    = m_run && m_h == 0 && m_v == 0;
        src0  = fs ? SRC_SEL_I : m_src;
        de0   = m_run && m_h < HA && m_v < VA;
        hs0   = m_run && m_h >= HA + HF && m_h < HA + HF + HS;
        vs0   = m_run && m_v >= VA + VF && m_v < VA + VF + VS;
        addr0 = m_v * HA + m_h;

        chk("frame_start", FRAME_START_O, fs);
        chk("busy", BUSY_O, m_run);
        chk("pat_en", PAT_EN_O, de0 && !src0);
        chk("fb_rd_en", FB_RD_EN_O, de0 && src0);
        if (de0)         chk("fb_addr", FB_ADDR_O, addr0);
        else if (!m_run) chk("fb_addr_idle", FB_ADDR_O, 0);
        chk("hsync", HSYNC_O, !e2_hs);
        chk("vsync", VSYNC_O, !e2_vs);
        chk("de", DE_O, e2_de);
        chk("rgb", VGA_RGB_O, e2_rgb);

        pat_en_prev  = PAT_EN_O;
        fb_en_prev   = FB_RD_EN_O;
        fb_addr_prev = FB_ADDR_O;

        e2_hs  = e1_hs;
        e2_vs  = e1_vs;
        e2_de  = e1_de;
        e2_rgb = !e1_de ? 12'h000 : (e1_src ? 12'(e1_addr) : pat_cur);
        e1_hs = hs0; e1_vs = vs0; e1_de = de0; e1_src = src0; e1_addr = addr0;

        if (RST_I) begin
            m_run = 0; m_src = 0; m_h = 0; m_v = 0;
            e1_hs = 0; e1_vs = 0; e1_de = 0; e1_src = 0;
            e2_hs = 0; e2_vs = 0; e2_de = 0; e2_rgb = 12'h000;
        end else begin
            if (fs) m_src = SRC_SEL_I;
            if (m_run) begin
                bit wrap;
                wrap = (m_h == HT - 1) && (m_v == VT - 1);
                if (m_h == HT - 1) begin
                    m_h = 0;
                    m_v = (m_v == VT - 1) ? 0 : m_v + 1;
                end else begin
                    m_h++;
                end
                if (wrap && !ENABLE_I) m_run = 0;
            end else if (ENABLE_I) begin
                m_run = 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_fs();
        bit ok = 0;
        for (int i = 0; i < 2 * HT * VT + 10; i++) begin
            @(negedge clk);
            if (FRAME_START_O) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL fs_timeout: no FRAME_START_O within bound at %0t", $time);
        end
    endtask

    // Starts at the negedge of a frame-start cycle; ends at the next frame-start negedge.
    task automatic measure_frame(output int de_n, output int hs_n, output int vs_n,
                                 output int hs_first, output int fb_n, output int amax,
                                 output logic [11:0] rgb_p0, output logic [11:0] rgb_l1);
        de_n = 0; hs_n = 0; vs_n = 0; hs_first = -1; fb_n = 0; amax = 0;
        rgb_p0 = 12'h000; rgb_l1 = 12'h000;
        for (int i = 0; i < HT * VT; i++) begin
            if (DE_O) de_n++;
            if (!HSYNC_O) begin hs_n++; if (hs_first < 0) hs_first = i; end
            if (!VSYNC_O) vs_n++;
            if (FB_RD_EN_O) begin
                fb_n++;
                if (int'(FB_ADDR_O) > amax) amax = int'(FB_ADDR_O);
            end
            if (i == 2)      rgb_p0 = VGA_RGB_O;
            if (i == HT + 2) rgb_l1 = VGA_RGB_O;
            @(negedge clk);
        end
    endtask

    initial begin
        int de_n, hs_n, vs_n, hs_first, fb_n, amax, waited;
        logic [11:0] rgb_p0, rgb_l1;

        RST_I = 1; ENABLE_I = 0; SRC_SEL_I = 0;
        PAT_PIXEL_I = 12'h000; FB_PIXEL_I = 12'h000;

        // reset and start
        cyc(5);
        RST_I = 0;
        @(negedge clk);
        chk("rst_hsync", HSYNC_O, 1);
        chk("rst_vsync", VSYNC_O, 1);
        chk("rst_busy", BUSY_O, 0);
        chk("rst_rgb", VGA_RGB_O, 0);
        cyc(1);
        ENABLE_I = 1;
        @(negedge clk);
        chk("fs_not_yet", FRAME_START_O, 0);
        @(negedge clk);
        chk("fs_first", FRAME_START_O, 1);
        @(negedge clk);
        chk("de_plus1", DE_O, 0);
        @(negedge clk);
        chk("de_plus2", DE_O, 1);

        // pattern path timing frame
        wait_fs();
        measure_frame(de_n, hs_n, vs_n, hs_first, fb_n, amax, rgb_p0, rgb_l1);
        chk("pat_de_count", de_n, HA * VA);
        chk("pat_hs_count", hs_n, HS * VT);
        chk("pat_vs_count", vs_n, VS * HT);
        chk("pat_hs_first", hs_first, HA + HF + 2);
        chk("pat_no_fb", fb_n, 0);
        chk("pat_rgb_p0", rgb_p0, 12'hF00);

        // frame-buffer path
        cyc(1);
        SRC_SEL_I = 1;
        wait_fs();
        measure_frame(de_n, hs_n, vs_n, hs_first, fb_n, amax, rgb_p0, rgb_l1);
        chk("fb_rd_count", fb_n, HA * VA);
        chk("fb_addr_max", amax, HA * VA - 1);
        chk("fb_rgb_l1p0", rgb_l1, 12'h010);
        chk("fb_addr_restart", FB_ADDR_O, 0);

        // mid-frame source switch with random pattern data
        cyc(1);
        pat_const = 0;
        SRC_SEL_I = 0;
        wait_fs();
        cyc(3 * HT);
        SRC_SEL_I = 1;
        wait_fs();
        chk("switch_fb_first", FB_RD_EN_O, 1);
        chk("switch_pat_off", PAT_EN_O, 0);

        // stop and drain
        cyc(4 * HT);
        ENABLE_I = 0;
        waited = 4 * HT;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!BUSY_O) break;
            waited++;
        end
        chk("drain_len", waited, HT * VT);
        repeat (2) @(negedge clk);
        chk("idle_hsync", HSYNC_O, 1);
        chk("idle_vsync", VSYNC_O, 1);
        chk("idle_de", DE_O, 0);
        chk("idle_rgb", VGA_RGB_O, 0);
        chk("idle_addr", FB_ADDR_O, 0);

        // re-enable during drain keeps the frame running
        cyc(1);
        ENABLE_I = 1;
        wait_fs();
        cyc(2 * HT);
        ENABLE_I = 0;
        cyc(3 * HT);
        ENABLE_I = 1;
        waited = 5 * HT;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (FRAME_START_O) break;
            waited++;
        end
        chk("reenable_period", waited, HT * VT);

        // randomized run/stop/source/reset traffic against the model
        for (int k = 0; k < 3000; k++) begin
            cyc(1);
            RST_I = ($urandom_range(0, 1499) == 0);
            if ($urandom_range(0, 199) == 0) ENABLE_I = !ENABLE_I;
            if ($urandom_range(0, 49) == 0)  SRC_SEL_I = 1'($urandom_range(0, 1));
        end
        cyc(1);
        RST_I = 0;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_display_controller.md
Name: vga_display_controller

Overview:
- Sequences the 25 MHz pixel datapath for 640x480@60 VGA output.
- Generates the raster counters and HSYNC/VSYNC.
- Drives the enable of the colour-bar test-pattern generator and the read port of the camera frame buffer.
- Muxes the selected 12-bit RGB444 source onto the VGA pins, with sync and data edges aligned.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of HSYNC_O/VSYNC_O (0 = active-low)
- ADDR_W, 19, frame-buffer address width

Ports:
- CLK_25_I  in  1  25 MHz pixel clock; the only clock
- RST_I  in  1  synchronous, active-high reset
- ENABLE_I  in  1  run request; level-sensitive
- SRC_SEL_I  in  1  0 = test pattern, 1 = frame buffer; sampled at frame start only
- PAT_EN_O  out  1  enable to the pattern generator
- PAT_PIXEL_I  in  12  pattern RGB444; valid 1 cycle after PAT_EN_O
- FB_RD_EN_O  out  1  frame-buffer read strobe
- FB_ADDR_O  out  ADDR_W  frame-buffer read address
- FB_PIXEL_I  in  12  frame-buffer RGB444; valid 1 cycle after FB_RD_EN_O
- VGA_RGB_O  out  12  RGB444 to the DAC
- HSYNC_O  out  1  horizontal sync
- VSYNC_O  out  1  vertical sync
- DE_O  out  1  data enable, aligned with VGA_RGB_O
- FRAME_START_O  out  1  1-cycle pulse at h=0, v=0 of every running frame
- BUSY_O  out  1  1 while not IDLE

Behaviour:
- Clocking and reset:
  - One clock, CLK_25_I. RST_I is synchronous and active-high.
  - In reset: h/v counters = 0, state = IDLE, address = 0.
  - In reset: HSYNC_O = VSYNC_O = ~SYNC_POL; DE_O, VGA_RGB_O, PAT_EN_O, FB_RD_EN_O, FRAME_START_O and BUSY_O = 0.
  - RST_I mid-frame takes effect on the next edge; no frame completion.
- Raster counters:
  - H_TOTAL = 800 and V_TOTAL = 525, both derived from the parameters.
  - h wraps H_TOTAL-1 -> 0 and increments v; v wraps V_TOTAL-1 -> 0.
  - Counters hold at 0 in IDLE.
- State machine:
  - IDLE -> RUN when ENABLE_I = 1. Counters start at (0,0) on the next cycle.
  - RUN -> DRAIN when ENABLE_I = 0. The current frame completes.
  - DRAIN -> IDLE on the wrap at (H_TOTAL-1, V_TOTAL-1).
  - DRAIN -> RUN if ENABLE_I returns before that wrap; the frame is not interrupted.
  - If ENABLE_I = 0 exactly at the wrap cycle in RUN, go directly to IDLE.
- Source selection:
  - src_q latches SRC_SEL_I at each frame start (h=0, v=0).
  - A mid-frame SRC_SEL_I change has no effect until the next frame.
- Stage 0 (combinational from counters):
  - active = (h < H_ACTIVE) && (v < V_ACTIVE) && state != IDLE.
  - PAT_EN_O = active && !src_q; FB_RD_EN_O = active && src_q.
  - Decode uses the SRC_SEL_I value being latched, so the first pixel of the frame is correct.
- Frame-buffer address:
  - FB_ADDR_O equals the current frame pixel index, v*H_ACTIVE + h.
  - Generated incrementally: +1 per active cycle, cleared at frame start. No multiplier.
- Sync generation (stage 0, pre-pipeline):
  - hsync asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
  - Both are valid in any non-IDLE state.
- Pipeline and latency:
  - hsync, vsync, active and src_q are delayed 2 registers.
  - Cycle n+1: source pixel arrives.
  - Cycle n+2: VGA_RGB_O = delayed src ? FB_PIXEL_I_q : PAT_PIXEL_I_q, forced to 0 when delayed active = 0.
  - Total latency from counter state to pins is 2 cycles, identical for sync, DE and RGB.
- Pulses:
  - FRAME_START_O is undelayed, stage-0 timing. It lets the camera side swap buffers ahead of the first read.
- Arithmetic:
  - Counters are 10 bits, unsigned; comparisons are unsigned.
  - ADDR_W must be >= clog2(H_ACTIVE*V_ACTIVE).

Decomposition:
- Shared package vga_pkg:
  - The timing localparams and derived totals.
  - The RGB444 colour constants already used by the pattern generator.
  - The state encoding (IDLE, RUN, DRAIN).
- One sub-module, vga_timing_counter:
  - h/v counters, wrap, sync and active decode.
- Top level:
  - The FSM, source latch, address generator, alignment pipeline and output mux.

Test Plan:
- Reset and start: RST_I high 5 cycles, then ENABLE_I=1, SRC_SEL_I=0.
  - HSYNC_O and VSYNC_O stay 1.
  - First FRAME_START_O 1 cycle after ENABLE_I is seen.
  - DE_O rises exactly 2 cycles after FRAME_START_O.
- Line and frame timing: run 2 frames.
  - HSYNC_O low for 96 clocks of every 800-clock period, starting 656+2 clocks after line start.
  - VSYNC_O low for exactly 2 lines.
  - DE_O high for 640 clocks x 480 lines per frame.
- Pattern path: SRC_SEL_I=0, PAT_PIXEL_I = 12'hF00 constant.
  - VGA_RGB_O = F00 during every DE_O=1 cycle, 000 otherwise.
  - FB_RD_EN_O never asserts.
- Frame-buffer path: SRC_SEL_I=1, model a 1-cycle-latency RAM returning data = addr[11:0].
  - FB_ADDR_O runs 0..307199 then restarts at 0.
  - VGA_RGB_O on line 1, pixel 0 = 12'h280 (640 mod 4096).
- Mid-frame source switch: toggle SRC_SEL_I 0 -> 1 at v=100.
  - No source change until the next FRAME_START_O.
  - First pixel of the next frame comes from the FB.
- Stop and drain: drop ENABLE_I at v=200.
  - Frame finishes; BUSY_O falls after the wrap at (799,524).
  - Outputs return to reset values.
  - Re-asserting ENABLE_I at v=300 of a separate run keeps RUN with no glitch in HSYNC_O.
